// File: rtl/dec_sb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dec_sb: RV32I decode stage with register file, writeback bypass and        |
// |         in-order destination scoreboard (RAW stall, valid/ready both sides) |
// | Optional feature macro: DEC_WB_BYPASS_EN  (same-cycle writeback forwarding) |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module dec_sb #(
  parameter int XLEN     = 32,
  parameter int SB_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush_i,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [10:0]     out_opcode,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_shamt,
  output logic            sb_full
);

`ifdef DEC_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam int CW = $clog2(SB_DEPTH + 1);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [6:0]      opc;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign opc    = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign imm_i  = XLEN'($signed(in_instr[31:20]));
  assign imm_s  = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b  = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                 in_instr[11:8], 1'b0}));
  assign imm_j  = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0}));
  assign imm_u  = XLEN'($signed({in_instr[31:12], 12'b0}));

  logic [4:0]      dec_rd, dec_shamt;
  logic            use_rs1, use_rs2;
  logic [XLEN-1:0] dec_imm;
  logic [4:0]      rs1, rs2;

  always_comb begin
    dec_rd    = 5'd0;
    dec_shamt = 5'd0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    dec_imm   = '0;
    case (opc)
      OP_LUI, OP_AUIPC: begin
        dec_rd  = in_instr[11:7];
        dec_imm = imm_u;
      end
      OP_JAL: begin
        dec_rd  = in_instr[11:7];
        dec_imm = imm_j;
      end
      OP_JALR, OP_LOAD: begin
        dec_rd  = in_instr[11:7];
        use_rs1 = 1'b1;
        dec_imm = imm_i;
      end
      OP_IMM: begin
        dec_rd  = in_instr[11:7];
        use_rs1 = 1'b1;
        // SLLI/SRLI/SRAI carry the shift amount separately, not as an immediate
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_shamt = in_instr[24:20];
        end else begin
          dec_imm = imm_i;
        end
      end
      OP_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec_imm = imm_s;
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec_imm = imm_b;
      end
      OP_REG: begin
        dec_rd  = in_instr[11:7];
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign rs1 = use_rs1 ? in_instr[19:15] : 5'd0;
  assign rs2 = use_rs2 ? in_instr[24:20] : 5'd0;

  // Register file; entry 0 is never written so it reads as zero
  logic [XLEN-1:0] rf_q [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_valid && wb_rd != 5'd0) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  logic [XLEN-1:0] rs1_val, rs2_val;

  always_comb begin
    rs1_val = rf_q[rs1];
    rs2_val = rf_q[rs2];
    if (BYPASS && wb_valid && wb_rd == rs1 && rs1 != 5'd0) rs1_val = wb_data;
    if (BYPASS && wb_valid && wb_rd == rs2 && rs2 != 5'd0) rs2_val = wb_data;
  end

  // Scoreboard kept compacted: entry 0 is always the oldest in-flight rd
  logic [4:0]    sb_q [SB_DEPTH];
  logic [4:0]    sb_d [SB_DEPTH];
  logic [CW-1:0] sb_cnt_q, sb_cnt_d;
  logic          pop, raw, full_haz, hazard, issue;
  logic [CW-1:0] cnt_eff;

  logic            out_valid_q;
  logic [10:0]     out_opcode_q;
  logic [XLEN-1:0] out_rs1_q, out_rs2_q, out_imm_q, out_pc_q;
  logic [4:0]      out_rd_q, out_shamt_q;

  assign pop = wb_valid && (sb_cnt_q != '0);

  always_comb begin
    raw = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (CW'(i) < sb_cnt_q && !(BYPASS && pop && i == 0)) begin
        if ((rs1 != 5'd0 && sb_q[i] == rs1) || (rs2 != 5'd0 && sb_q[i] == rs2)) begin
          raw = 1'b1;
        end
      end
    end
  end

  assign cnt_eff  = sb_cnt_q - CW'(BYPASS && pop);
  assign full_haz = (cnt_eff == CW'(SB_DEPTH)) && (dec_rd != 5'd0);
  assign hazard   = raw | full_haz;
  assign issue    = in_valid & ~hazard & ~flush_i & (~out_valid_q | out_ready);
  assign in_ready = issue | ~in_valid;

  always_comb begin
    sb_d     = sb_q;
    sb_cnt_d = sb_cnt_q;
    if (pop) begin
      for (int i = 0; i < SB_DEPTH - 1; i++) sb_d[i] = sb_q[i + 1];
      sb_cnt_d = sb_cnt_d - CW'(1);
    end
    // A squashed instruction owns the youngest entry unless it already retired
    if (flush_i && out_valid_q && out_rd_q != 5'd0 && sb_cnt_d != '0) begin
      sb_cnt_d = sb_cnt_d - CW'(1);
    end
    if (issue && dec_rd != 5'd0) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        if (CW'(i) == sb_cnt_d) sb_d[i] = dec_rd;
      end
      sb_cnt_d = sb_cnt_d + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SB_DEPTH; i++) sb_q[i] <= 5'd0;
      sb_cnt_q <= '0;
    end else begin
      sb_q     <= sb_d;
      sb_cnt_q <= sb_cnt_d;
    end
  end

  assign sb_full = (sb_cnt_q == CW'(SB_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_opcode_q <= 11'd0;
      out_rs1_q    <= '0;
      out_rs2_q    <= '0;
      out_imm_q    <= '0;
      out_rd_q     <= 5'd0;
      out_pc_q     <= '0;
      out_shamt_q  <= 5'd0;
    end else if (issue) begin
      out_valid_q  <= 1'b1;
      out_opcode_q <= {(in_instr[31:25] != 7'd0), funct3, opc};
      out_rs1_q    <= rs1_val;
      out_rs2_q    <= rs2_val;
      out_imm_q    <= dec_imm;
      out_rd_q     <= dec_rd;
      out_pc_q     <= in_pc;
      out_shamt_q  <= dec_shamt;
    end else if (out_ready || flush_i) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_opcode  = out_opcode_q;
  assign out_rs1_val = out_rs1_q;
  assign out_rs2_val = out_rs2_q;
  assign out_imm     = out_imm_q;
  assign out_rd      = out_rd_q;
  assign out_pc      = out_pc_q;
  assign out_shamt   = out_shamt_q;

endmodule
`default_nettype wire

// File: tb/tb_dec_sb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dec_sb: randomized and directed bench for dec_sb against a queue model   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_dec_sb;

`ifdef DEC_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic        flush_i = 1'b0, wb_valid = 1'b0, out_ready = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid, sb_full;
  logic [10:0] out_opcode;
  logic [31:0] out_rs1_val, out_rs2_val, out_imm, out_pc;
  logic [4:0]  out_rd, out_shamt;

  dec_sb #(.XLEN(32), .SB_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush_i(flush_i), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
    .out_rd(out_rd), .out_pc(out_pc), .out_shamt(out_shamt), .sb_full(sb_full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] opc;
    logic [4:0]  rd, rs1, rs2, sh;
    logic [31:0] imm;
  } dec_t;

  int          n_cmp = 0, n_err = 0;
  logic [31:0] m_rf [32];
  int          m_q [$];
  logic        m_ov;
  dec_t        m_od;
  logic [31:0] m_v1, m_v2, m_pc;
  logic        s_ready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference decode from the ISA field tables, immediates by integer arithmetic
  function automatic dec_t ref_dec(input logic [31:0] ins);
    dec_t d;
    int   v;
    logic [6:0] op;
    logic [2:0] f;
    d  = '0;
    op = ins[6:0];
    f  = ins[14:12];
    v  = 0;
    d.opc = {ins[31:25] != 7'd0, f, op};
    case (op)
      7'h37, 7'h17: begin d.rd = ins[11:7]; d.imm = {ins[31:12], 12'h000}; end
      7'h6F: begin
        d.rd = ins[11:7];
        v = int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * (1 << 12)
          + int'(ins[20]) * (1 << 11) + int'(ins[30:21]) * 2;
        if (v >= (1 << 20)) v -= (1 << 21);
        d.imm = v;
      end
      7'h67, 7'h03, 7'h13: begin
        d.rd = ins[11:7]; d.rs1 = ins[19:15];
        if (op == 7'h13 && (f == 3'd1 || f == 3'd5)) d.sh = ins[24:20];
        else begin
          v = int'(ins[31:20]);
          if (v >= 2048) v -= 4096;
          d.imm = v;
        end
      end
      7'h23: begin
        d.rs1 = ins[19:15]; d.rs2 = ins[24:20];
        v = int'(ins[31:25]) * 32 + int'(ins[11:7]);
        if (v >= 2048) v -= 4096;
        d.imm = v;
      end
      7'h63: begin
        d.rs1 = ins[19:15]; d.rs2 = ins[24:20];
        v = int'(ins[31]) * 4096 + int'(ins[7]) * 2048
          + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        if (v >= 4096) v -= 8192;
        d.imm = v;
      end
      7'h33: begin d.rd = ins[11:7]; d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'h13};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] r, input logic wv,
                                       input logic [4:0] wrd, input logic [31:0] wd);
    if (r == 5'd0) return 32'd0;
    if (BYP && wv && wrd == r) return wd;
    return m_rf[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_q.delete();
    m_ov = 1'b0; m_od = '0; m_v1 = '0; m_v2 = '0; m_pc = '0;
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("sb_full", 32'(sb_full), 32'(m_q.size() == DEPTH));
    chk("out_opcode", 32'(out_opcode), 32'(m_od.opc));
    chk("out_rs1_val", out_rs1_val, m_v1);
    chk("out_rs2_val", out_rs2_val, m_v2);
    chk("out_imm", out_imm, m_od.imm);
    chk("out_rd", 32'(out_rd), 32'(m_od.rd));
    chk("out_pc", out_pc, m_pc);
    chk("out_shamt", 32'(out_shamt), 32'(m_od.sh));
  endtask

  // One clock: drive at negedge, check handshake, advance model, check outputs
  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                      input logic fl, input logic wv, input logic [4:0] wrd,
                      input logic [31:0] wd, input logic ordy);
    dec_t        d;
    logic        pop, haz, iss;
    int          cnt;
    logic [31:0] v1, v2;
    @(negedge clk);
    in_valid = iv; in_instr = ins; in_pc = pc; flush_i = fl;
    wb_valid = wv; wb_rd = wrd; wb_data = wd; out_ready = ordy;
    #1;
    d   = ref_dec(ins);
    pop = wv && (m_q.size() > 0);
    haz = 1'b0;
    foreach (m_q[k]) begin
      if (!(BYP && pop && k == 0) &&
          ((d.rs1 != 0 && m_q[k] == int'(d.rs1)) || (d.rs2 != 0 && m_q[k] == int'(d.rs2))))
        haz = 1'b1;
    end
    cnt = m_q.size() - ((BYP && pop) ? 1 : 0);
    if (cnt == DEPTH && d.rd != 0) haz = 1'b1;
    iss = iv && !haz && !fl && (!m_ov || ordy);
    s_ready = in_ready;
    chk("in_ready", 32'(in_ready), 32'(iv ? iss : 1'b1));
    v1 = opnd(d.rs1, wv, wrd, wd);
    v2 = opnd(d.rs2, wv, wrd, wd);
    @(posedge clk);
    #1;
    if (wv && wrd != 0) m_rf[wrd] = wd;
    if (pop) void'(m_q.pop_front());
    if (fl && m_ov && m_od.rd != 0 && m_q.size() > 0) void'(m_q.pop_back());
    if (iss) begin
      if (d.rd != 0) m_q.push_back(int'(d.rd));
      m_ov = 1'b1; m_od = d; m_v1 = v1; m_v2 = v2; m_pc = pc;
    end else if (ordy || fl) begin
      m_ov = 1'b0;
    end
    check_outputs();
  endtask

  task automatic do_reset();
    #2;
    in_valid = 1'b0; flush_i = 1'b0; wb_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sb_full", 32'(sb_full), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_outputs", out_rs1_val | out_rs2_val | out_imm | out_pc |
        32'(out_opcode) | 32'(out_rd) | 32'(out_shamt), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [6:0] OPS [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13,
                           7'h23, 7'h63, 7'h33, 7'h0F, 7'h73, 7'h7F};

  task automatic rnd_step();
    logic [31:0] ins;
    logic [4:0]  wrd;
    logic        wv;
    ins        = $urandom;
    ins[6:0]   = OPS[$urandom_range(0, 11)];
    ins[11:7]  = 5'($urandom_range(0, 7));
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    wv  = ($urandom_range(0, 2) == 0);
    wrd = (m_q.size() > 0) ? 5'(m_q[0]) : 5'($urandom_range(0, 7));
    step($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 15) == 0,
         wv, wrd, $urandom, $urandom_range(0, 3) != 0);
  endtask

  initial begin
    model_reset();
    do_reset();

    // Immediate formats
    step(1'b1, 32'hFFF00093, 32'h100, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("addi_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_rd", 32'(out_rd), 32'd1);
    step(1'b1, 32'hFE000EE3, 32'h104, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("beq_imm", out_imm, 32'hFFFFFFFC);
    step(1'b1, 32'h12345137, 32'h108, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("lui_imm", out_imm, 32'h12345000);
    chk("lui_rd", 32'(out_rd), 32'd2);

    // Regfile write, then reset clears it
    do_reset();
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd5, 32'hDEAD, 1'b1);
    step(1'b1, enc_r(5'd9, 5'd5, 5'd5), 32'h200, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("rf_read", out_rs1_val, 32'hDEAD);
    do_reset();
    step(1'b1, enc_r(5'd9, 5'd5, 5'd5), 32'h204, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("rf_after_rst", out_rs1_val, 32'd0);

    // RAW stall on x3
    do_reset();
    step(1'b1, enc_i(5'd3, 5'd0, 12'd7), 32'h300, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    step(1'b1, enc_r(5'd4, 5'd3, 5'd3), 32'h304, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("raw_stall", 32'(s_ready), 32'd0);
    step(1'b1, enc_r(5'd4, 5'd3, 5'd3), 32'h304, 1'b0, 1'b1, 5'd3, 32'h55, 1'b1);
`ifdef DEC_WB_BYPASS_EN
    chk("raw_wb_issue", 32'(s_ready), 32'd1);
`else
    chk("raw_wb_stall", 32'(s_ready), 32'd0);
    step(1'b1, enc_r(5'd4, 5'd3, 5'd3), 32'h304, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("raw_next_issue", 32'(s_ready), 32'd1);
`endif
    chk("raw_rs1", out_rs1_val, 32'h55);
    chk("raw_rs2", out_rs2_val, 32'h55);

    // Full scoreboard
    do_reset();
    step(1'b1, enc_i(5'd1, 5'd0, 12'd1), 32'h400, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    step(1'b1, enc_i(5'd2, 5'd0, 12'd2), 32'h404, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    step(1'b1, enc_i(5'd5, 5'd0, 12'd3), 32'h408, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("full_stall", 32'(s_ready), 32'd0);
    chk("full_flag", 32'(sb_full), 32'd1);
    step(1'b1, enc_i(5'd5, 5'd0, 12'd3), 32'h408, 1'b0, 1'b1, 5'd1, 32'h11, 1'b1);
`ifdef DEC_WB_BYPASS_EN
    chk("full_wb_issue", 32'(s_ready), 32'd1);
`else
    chk("full_wb_stall", 32'(s_ready), 32'd0);
    step(1'b1, enc_i(5'd5, 5'd0, 12'd3), 32'h408, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("full_next_issue", 32'(s_ready), 32'd1);
`endif
    chk("full_rd", 32'(out_rd), 32'd5);

    // Flush of a held ADDI x6
    do_reset();
    step(1'b1, enc_i(5'd6, 5'd0, 12'd9), 32'h500, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    step(1'b1, enc_r(5'd7, 5'd6, 5'd6), 32'h504, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("flush_nostall", 32'(s_ready), 32'd1);

    // Backpressure
    do_reset();
    step(1'b1, enc_i(5'd8, 5'd0, 12'd8), 32'h600, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, enc_i(5'd9, 5'd0, 12'd9), 32'h604, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      chk("bp_stall", 32'(s_ready), 32'd0);
      chk("bp_hold_rd", 32'(out_rd), 32'd8);
      chk("bp_hold_imm", out_imm, 32'd8);
    end
    step(1'b1, enc_i(5'd9, 5'd0, 12'd9), 32'h604, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("bp_release", 32'(s_ready), 32'd1);
    chk("bp_new_rd", 32'(out_rd), 32'd9);

    // Randomized traffic with a reset in the middle
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      rnd_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
